uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
- Memory-mapped buffered UART transmitter on the 8-bit CPU data bus, in the same I/O device slot style as the existing UART.
- Sits directly downstream of the memory controller's I/O decode. It consumes writeEnable/readEnable/regSelect/writeData strobes and returns read data on Data for the memory read mux.
- CPU stores bytes into a FIFO. A serializer drains them onto tx as 8N1 frames, so the CPU never stalls on a busy line.

Parameters:
- CLKS_PER_BIT, 104: clk cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 8: transmit FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- writeEnable  input  1  bus write strobe for this device, one cycle per access.
- readEnable  input  1  bus read select for this device.
- regSelect  input  2  register index within the device.
- writeData  input  8  bus write data.
- Data  output  8  register read data, combinational from regSelect.
- tx  output  1  serial line; idles high.
- irq  output  1  level interrupt, high when FIFO empty AND control.irqEn.

Behaviour:
- Reset (reset low, asynchronous):
  - tx=1, irq=0, FIFO empty, FSM in IDLE, counters 0.
  - control=0x01 (enabled), overflow flag cleared.
  - A frame in progress is abandoned and tx returns high immediately.
- Register map:
  - 0 TXDATA: write pushes writeData; read returns 0x00.
  - 1 STATUS (read): bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits7:4 FIFO count, saturated at 15.
  - 1 STATUS (write): any write clears overflow.
  - 2 CONTROL (read/write): bit0 txEn, bit1 irqEn, others read 0.
  - 3: reserved; reads 0x00, writes ignored.
- Data is defined only while readEnable is high; otherwise 0x00. Reads have no side effects.
- Push (writeEnable && regSelect==0):
  - Not full: byte written at the tail, count+1 on the next edge.
  - Full: byte dropped, overflow set.
  - Exception: if a pop occurs the same cycle, the push is accepted and count is unchanged.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count register is one bit wider so a full FIFO is distinguishable from an empty one.
- FSM states:
  - IDLE: when txEn && !empty, pop the head into the shift register, clear baud counter, go to START on the next edge. The first start-bit cycle is the cycle after the pop.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB first, each CLKS_PER_BIT cycles; 3-bit bit counter, after bit 7 go to STOP (or PARITY if enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Back-to-back frames: a new frame may start the cycle after STOP ends, i.e. one idle clock between frames, with tx held high.
- Clearing txEn mid-frame lets the current frame complete; no further pops occur.
- Frame length is exactly 10*CLKS_PER_BIT clk cycles without parity.
- irq is registered and updates one cycle after empty/irqEn changes.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - CONTROL bit2 = parEn, bit3 = parOdd.
  - When parEn=1, a PARITY state between DATA and STOP sends one bit for CLKS_PER_BIT cycles. Even parity is the XOR of the data bits; odd parity is its inverse.
  - Frame length with parity enabled is 11*CLKS_PER_BIT.
- Not defined: CONTROL bits 3:2 read 0 and are not writable; no PARITY state exists.

Test Plan:
- Reset: assert reset low mid-frame at CLKS_PER_BIT=4 -> tx=1 same cycle. After release: STATUS reads 0x02, CONTROL reads 0x01.
- Single byte: write 0x55 to reg0, CLKS_PER_BIT=4 -> tx low for 4 cycles starting 1 cycle after pop, then 1,0,1,0,1,0,1,0 each 4 cycles, then high 4 cycles. busy is 1 for exactly 40 cycles.
- Fill and overflow: with txEn=0, write 9 bytes 0x01..0x09 -> STATUS=0x89 (count 8, overflow, full). After clearing overflow and setting txEn=1, bytes 0x01..0x08 appear in order on tx and 0x09 never appears.
- Push while full with simultaneous pop: FIFO full, txEn=1, write 0xAA on the pop cycle -> count stays 8, no overflow; 0xAA is the last byte transmitted.
- IRQ: CONTROL=0x03, push one byte -> irq falls 1 cycle after push and rises 1 cycle after the pop empties the FIFO.
- Parity build only: CONTROL=0x05 (even), send 0x07 -> parity bit 1, frame length 44 cycles at CLKS_PER_BIT=4. With CONTROL=0x0D (odd) -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bus-written FIFO drained by a registered serializer FSM.
// Optional parity bit selected at build time with `define UART_TX_PARITY_EN.
module uart_tx_buffered #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       writeEnable,
  input  logic       readEnable,
  input  logic [1:0] regSelect,
  input  logic [7:0] writeData,
  output logic [7:0] Data,
  output logic       tx,
  output logic       irq
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic [7:0]    CTRL_MASK = 8'h0F;
`else
  localparam logic [7:0]    CTRL_MASK = 8'h03;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            irq_q, irq_d;
  logic [7:0]      ctrl_q, ctrl_d;
  logic            ovf_q, ovf_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic            par_bit_q, par_bit_d;
  logic            par_en_q, par_en_d;
`endif

  logic       full, empty, push_req, push, pop, baud_done;
  logic [7:0] head;
  logic [4:0] count_ext;
  logic [3:0] count_sat;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign push_req  = writeEnable && (regSelect == 2'd0);
  assign pop       = (state_q == IDLE) && ctrl_q[0] && !empty;
  // A pop in the same cycle frees the slot the push lands in, so a full FIFO still accepts.
  assign push      = push_req && (!full || pop);
  assign baud_done = (baud_q == BAUD_LAST);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    ctrl_d   = ctrl_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (writeEnable && (regSelect == 2'd1)) ovf_d = 1'b0;
    else if (push_req && !push)             ovf_d = 1'b1;
    if (writeEnable && (regSelect == 2'd2)) ctrl_d = writeData & CTRL_MASK;
    irq_d = empty && ctrl_q[1];
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
`ifdef UART_TX_PARITY_EN
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
`endif
    case (state_q)
      IDLE: begin
        if (pop) begin
          shreg_d = head;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_bit_d = (^head) ^ ctrl_q[3];
          par_en_d  = ctrl_q[2];
`endif
        end
      end
      START: begin
        baud_d = baud_done ? '0 : baud_q + 16'd1;
        if (baud_done) state_d = DATA;
      end
      DATA: begin
        baud_d = baud_done ? '0 : baud_q + 16'd1;
        if (baud_done) begin
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        baud_d = baud_done ? '0 : baud_q + 16'd1;
        if (baud_done) state_d = STOP;
      end
`endif
      STOP: begin
        baud_d = baud_done ? '0 : baud_q + 16'd1;
        if (baud_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // tx is registered against the next state so the line level lines up with the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_bit_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b0;
      ctrl_q   <= 8'h01;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      irq_q    <= irq_d;
      ctrl_q   <= ctrl_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef UART_TX_PARITY_EN
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= writeData;
  end

  assign count_ext = 5'(count_q);
  assign count_sat = count_ext[4] ? 4'hF : count_ext[3:0];

  always_comb begin
    Data = '0;
    if (readEnable) begin
      case (regSelect)
        2'd1:    Data = {count_sat, ovf_q, (state_q != IDLE), empty, full};
        2'd2:    Data = ctrl_q;
        default: Data = '0;
      endcase
    end
  end

  assign tx  = tx_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed plus randomized bench for uart_tx_buffered; a line decoder reconstructs bytes from tx.
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       we = 1'b0;
  logic       re = 1'b0;
  logic [1:0] rs = 2'd0;
  logic [7:0] wd = 8'h00;
  logic [7:0] data;
  logic       tx;
  logic       irq;

  int checks = 0;
  int errors = 0;
  logic       mon_en = 1'b0;
  logic [7:0] rxq[$];
  logic [7:0] expq[$];

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .writeEnable(we), .readEnable(re),
    .regSelect(rs), .writeData(wd), .Data(data), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    we = 1'b1; re = 1'b0; rs = a; wd = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    re = 1'b1; rs = a;
    @(negedge clk);
    d = data;
    re = 1'b0;
  endtask

  // Expected tx level per clock for one frame: start, 8 data bits LSB first, optional parity, stop.
  function automatic logic [63:0] exp_wave(input logic [7:0] b, input int nbits, input logic pbit);
    logic [10:0] fr;
    logic [63:0] w;
    fr = '0;
    fr[0] = 1'b0;
    fr[8:1] = b;
    if (nbits == 11) begin fr[9] = pbit; fr[10] = 1'b1; end
    else fr[9] = 1'b1;
    w = '0;
    for (int j = 0; j < nbits * CPB; j++) w[j] = fr[j / CPB];
    return w;
  endfunction

  task automatic capture(input int ncyc, output logic [63:0] w, output int busy);
    w = '0; busy = 0; re = 1'b1; rs = 2'd1;
    for (int j = 0; j < ncyc; j++) begin
      @(negedge clk);
      w[j] = tx;
      if (data[2]) busy++;
    end
  endtask

  task automatic frame_test(input string tag, input logic [7:0] b, input int nbits, input logic pbit);
    logic [63:0] w;
    int busy;
    bus_write(2'd0, b);
    re = 1'b1; rs = 2'd1;
    @(negedge clk);
    chk({tag, " idle before start"}, {62'd0, tx, data[2]}, 64'h2);
    capture(nbits * CPB, w, busy);
    chk({tag, " waveform"}, w, exp_wave(b, nbits, pbit));
    chk({tag, " busy cycles"}, 64'(busy), 64'(nbits * CPB));
    @(negedge clk);
    chk({tag, " idle after stop"}, {62'd0, tx, data[2]}, 64'h2);
    re = 1'b0;
  endtask

  task automatic wait_rx_and_compare(input string tag, input int limit);
    for (int c = 0; c < limit && rxq.size() < expq.size(); c++) @(negedge clk);
    repeat (30 * CPB) @(negedge clk);
    chk({tag, " byte count"}, 64'(rxq.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      chk($sformatf("%s byte %0d", tag, i), (i < rxq.size()) ? 64'(rxq[i]) : 64'hX, 64'(expq[i]));
  endtask

  // Line decoder: samples each bit mid-cell, independent of the DUT's internal timing.
  initial begin
    logic [7:0] b;
    int cur, tgt;
    forever begin
      @(negedge clk);
      if (mon_en && reset && tx === 1'b0) begin
        cur = 0;
        for (int i = 0; i < 8; i++) begin
          tgt = CPB * (1 + i) + CPB / 2;
          repeat (tgt - cur) @(negedge clk);
          cur = tgt;
          b[i] = tx;
        end
        tgt = CPB * 9 + CPB / 2;
        repeat (tgt - cur) @(negedge clk);
        cur = tgt;
        chk("stop bit", 64'(tx), 64'h1);
        rxq.push_back(b);
        repeat (10 * CPB - 1 - cur) @(negedge clk);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    int n, cnt;
    logic ovf;

    repeat (3) @(negedge clk);
    chk("reset tx", 64'(tx), 64'h1);
    chk("reset irq", 64'(irq), 64'h0);
    reset = 1'b1;
    bus_read(2'd1, d); chk("status after reset", 64'(d), 64'h02);
    bus_read(2'd2, d); chk("control after reset", 64'(d), 64'h01);
    bus_read(2'd3, d); chk("reg3 read", 64'(d), 64'h00);
    bus_read(2'd0, d); chk("txdata read", 64'(d), 64'h00);
    rs = 2'd2; re = 1'b0; @(negedge clk);
    chk("data without readEnable", 64'(data), 64'h00);

    bus_write(2'd0, 8'h00);
    repeat (10) @(negedge clk);
    chk("midframe tx low", 64'(tx), 64'h0);
    #2 reset = 1'b0;
    #1 chk("async reset tx", 64'(tx), 64'h1);
    chk("async reset irq", 64'(irq), 64'h0);
    @(negedge clk); reset = 1'b1;
    bus_read(2'd1, d); chk("status after midframe reset", 64'(d), 64'h02);
    bus_read(2'd2, d); chk("control after midframe reset", 64'(d), 64'h01);

    frame_test("byte 0x55", 8'h55, 10, 1'b0);

`ifdef UART_TX_PARITY_EN
    bus_write(2'd2, 8'h05);
    frame_test("even parity 0x07", 8'h07, 11, 1'b1);
    bus_write(2'd2, 8'h0D);
    frame_test("odd parity 0x07", 8'h07, 11, 1'b0);
    bus_write(2'd2, 8'h01);
`else
    bus_write(2'd2, 8'hFF);
    bus_read(2'd2, d); chk("control mask", 64'(d), 64'h03);
    bus_write(2'd2, 8'h01);
`endif

    bus_write(2'd2, 8'h03);
    repeat (2) @(negedge clk);
    chk("irq when empty", 64'(irq), 64'h1);
    bus_write(2'd0, 8'h3C);
    @(negedge clk); chk("irq before fall", 64'(irq), 64'h1);
    @(negedge clk); chk("irq fell", 64'(irq), 64'h0);
    @(negedge clk); chk("irq rose after pop", 64'(irq), 64'h1);
    repeat (12 * CPB) @(negedge clk);
    bus_write(2'd2, 8'h01);
    repeat (2) @(negedge clk);
    chk("irq cleared by irqEn", 64'(irq), 64'h0);

    mon_en = 1'b1;
    bus_write(2'd2, 8'h00);
    expq.delete(); rxq.delete();
    for (int i = 1; i <= 9; i++) begin
      bus_write(2'd0, 8'(i));
      if (i <= DEPTH) expq.push_back(8'(i));
    end
    bus_read(2'd1, d); chk("status full+overflow", 64'(d), 64'h89);
    bus_write(2'd1, 8'h00);
    bus_read(2'd1, d); chk("status overflow cleared", 64'(d), 64'h81);
    bus_write(2'd2, 8'h01);
    wait_rx_and_compare("fill", 12 * CPB * 10);
    bus_read(2'd1, d); chk("status drained", 64'(d), 64'h02);

    bus_write(2'd2, 8'h00);
    expq.delete(); rxq.delete();
    for (int i = 0; i < DEPTH; i++) begin
      bus_write(2'd0, 8'(8'h11 + i));
      expq.push_back(8'(8'h11 + i));
    end
    @(posedge clk); #1;
    we = 1'b1; rs = 2'd2; wd = 8'h01;
    @(posedge clk); #1;
    rs = 2'd0; wd = 8'hAA;
    @(posedge clk); #1;
    we = 1'b0;
    expq.push_back(8'hAA);
    bus_read(2'd1, d); chk("status push on pop", 64'(d), 64'h85);
    wait_rx_and_compare("full push+pop", 12 * CPB * 11);

    for (int it = 0; it < 4; it++) begin
      bus_write(2'd2, 8'h00);
      expq.delete(); rxq.delete();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        bus_write(2'd0, d);
        if (expq.size() < DEPTH) expq.push_back(d);
      end
      cnt = expq.size();
      ovf = (n > DEPTH);
      bus_read(2'd1, d);
      chk($sformatf("random status %0d", it), 64'(d),
          64'({4'(cnt), ovf, 1'b0, (cnt == 0), (cnt == DEPTH)}));
      bus_write(2'd1, 8'h00);
      bus_write(2'd2, 8'h01);
      wait_rx_and_compare($sformatf("random %0d", it), 12 * CPB * 10);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
